// File: rtl/fib_access_arbiter.sv
// FIB access arbiter: sole owner of the FIB hash unit and valid-bit table port.
// Serialises insert and longest-prefix-match lookup requests. Both-pending ties
// are settled round-robin. A lookup walks the prefix length down one bit at a
// time (hash, check, shorten) until a set bit is found or length 0 misses.
module fib_access_arbiter #(
  parameter int PREFIX_W = 64,
  parameter int HASH_W   = 10,
  parameter int LEN_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_req,
  input  logic [PREFIX_W-1:0] ins_prefix,
  input  logic [LEN_W-1:0]    ins_len,
  output logic                ins_done,
  input  logic                lkp_req,
  input  logic [PREFIX_W-1:0] lkp_prefix,
  input  logic [LEN_W-1:0]    lkp_len,
  output logic                lkp_done,
  output logic                lkp_hit,
  output logic [LEN_W-1:0]    lkp_match_len,
  output logic [PREFIX_W-1:0] lkp_match_prefix,
  output logic [PREFIX_W-1:0] hash_in,
  input  logic [HASH_W-1:0]   hash_val,
  output logic [LEN_W-1:0]    tbl_len,
  output logic [HASH_W-1:0]   tbl_idx,
  input  logic                tbl_rd_bit,
  output logic                tbl_we,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE, INS_HASH, INS_WRITE, LK_HASH, LK_CHECK, LK_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  rr_lkp_q, rr_lkp_d;   // 1: lookup was granted last
  logic [LEN_W-1:0]      len_q, len_d;         // current search/insert length
  logic [PREFIX_W-1:0]   cur_q, cur_d;         // masked prefix, drives hash_in
  logic                  hit_q, hit_d;
  logic [LEN_W-1:0]      mlen_q, mlen_d;
  logic [PREFIX_W-1:0]   mpref_q, mpref_d;

  // Bits [l:0] set, everything above cleared.
  function automatic logic [PREFIX_W-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [PREFIX_W-1:0] m;
    m = '0;
    for (int i = 0; i < PREFIX_W; i++) m[i] = (i <= int'(l));
    return m;
  endfunction

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_lkp_q <= 1'b1;
      len_q    <= '0;
      cur_q    <= '0;
      hit_q    <= 1'b0;
      mlen_q   <= '0;
      mpref_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_lkp_q <= rr_lkp_d;
      len_q    <= len_d;
      cur_q    <= cur_d;
      hit_q    <= hit_d;
      mlen_q   <= mlen_d;
      mpref_q  <= mpref_d;
    end
  end

  // Next state: grant arbitration in IDLE and the LPM shorten loop.
  always_comb begin
    state_d  = state_q;
    rr_lkp_d = rr_lkp_q;
    len_d    = len_q;
    cur_d    = cur_q;
    hit_d    = hit_q;
    mlen_d   = mlen_q;
    mpref_d  = mpref_q;
    case (state_q)
      IDLE: begin
        // Insert wins alone, or on a tie when lookup was granted last.
        if (ins_req && (!lkp_req || rr_lkp_q)) begin
          len_d    = ins_len;
          cur_d    = ins_prefix & len_mask(ins_len);
          rr_lkp_d = 1'b0;
          state_d  = INS_HASH;
        end else if (lkp_req) begin
          len_d    = lkp_len;
          cur_d    = lkp_prefix & len_mask(lkp_len);
          rr_lkp_d = 1'b1;
          state_d  = LK_HASH;
        end
      end
      INS_HASH:  state_d = INS_WRITE;
      INS_WRITE: state_d = IDLE;
      LK_HASH:   state_d = LK_CHECK;
      LK_CHECK: begin
        if (tbl_rd_bit) begin
          hit_d   = 1'b1;
          mlen_d  = len_q;
          mpref_d = cur_q;
          state_d = LK_DONE;
        end else if (len_q == '0) begin
          hit_d   = 1'b0;
          mlen_d  = '0;
          mpref_d = '0;
          state_d = LK_DONE;
        end else begin
          // Dropping bit L of an L-masked prefix yields the (L-1)-masked one.
          cur_d[len_q] = 1'b0;
          len_d        = len_q - LEN_W'(1);
          state_d      = LK_HASH;
        end
      end
      LK_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; table address only meaningful on access cycles.
  always_comb begin
    busy     = (state_q != IDLE);
    ins_done = (state_q == INS_WRITE);
    tbl_we   = (state_q == INS_WRITE);
    lkp_done = (state_q == LK_DONE);
    tbl_len  = '0;
    tbl_idx  = '0;
    if (state_q == INS_WRITE || state_q == LK_CHECK) begin
      tbl_len = len_q;
      tbl_idx = hash_val;
    end
  end

  assign hash_in          = cur_q;
  assign lkp_hit          = hit_q;
  assign lkp_match_len    = mlen_q;
  assign lkp_match_prefix = mpref_q;

endmodule

// File: tb/tb_fib_access_arbiter.sv
// Bench for fib_access_arbiter: directed latency/result checks with literal
// expectations, then randomized insert/lookup traffic checked every cycle
// against a transaction-level model (set of (len,hash) keys, LPM by search).
module tb_fib_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_req, lkp_req;
  logic [63:0] ins_prefix, lkp_prefix;
  logic [5:0]  ins_len, lkp_len;
  logic        ins_done, lkp_done, lkp_hit, tbl_we, busy, tbl_rd_bit;
  logic [5:0]  lkp_match_len, tbl_len;
  logic [63:0] lkp_match_prefix, hash_in;
  logic [9:0]  hash_val = '0;
  logic [9:0]  tbl_idx;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int we_cnt = 0, ld_cnt = 0;
  int we_cyc = -1;
  logic [5:0] we_len;
  logic [9:0] we_idx;

  always #5 clk = ~clk;

  fib_access_arbiter dut (
    .clk(clk), .rst(rst),
    .ins_req(ins_req), .ins_prefix(ins_prefix), .ins_len(ins_len), .ins_done(ins_done),
    .lkp_req(lkp_req), .lkp_prefix(lkp_prefix), .lkp_len(lkp_len), .lkp_done(lkp_done),
    .lkp_hit(lkp_hit), .lkp_match_len(lkp_match_len), .lkp_match_prefix(lkp_match_prefix),
    .hash_in(hash_in), .hash_val(hash_val), .tbl_len(tbl_len), .tbl_idx(tbl_idx),
    .tbl_rd_bit(tbl_rd_bit), .tbl_we(tbl_we), .busy(busy)
  );

  function automatic logic [9:0] h(input logic [63:0] x);
    logic [63:0] m;
    m = x * 64'h9E3779B97F4A7C15;
    return m[63:54];
  endfunction

  function automatic logic [63:0] bmask(input int l);
    if (l >= 63) return '1;
    return (64'd1 << (l + 1)) - 64'd1;
  endfunction

  // Environment: registered hash unit and the valid-bit table.
  bit env_tbl [0:63][0:1023];
  always @(posedge clk) hash_val <= h(hash_in);
  always @(posedge clk) if (tbl_we) env_tbl[tbl_len][tbl_idx] <= 1'b1;
  assign tbl_rd_bit = env_tbl[tbl_len][tbl_idx];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (tbl_we) we_cnt <= we_cnt + 1;
  always @(posedge clk) if (lkp_done) ld_cnt <= ld_cnt + 1;
  always @(negedge clk) if (tbl_we) begin we_cyc = cyc; we_len = tbl_len; we_idx = tbl_idx; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          mset [int];
  int          op = 0;             // 0 none, 1 insert, 2 lookup
  int          t0, tdone, m_L, m_kmax;
  logic [63:0] m_p, m_cur, e_hash = '0;
  bit          m_rr_lkp = 1'b1;
  bit          p_hit, e_hit = 1'b0;
  logic [5:0]  p_len, e_mlen = '0;
  logic [63:0] p_pref, e_mpref = '0;

  always @(negedge clk) begin
    if (rst) begin
      op = 0; e_hit = 0; e_mlen = '0; e_mpref = '0; e_hash = '0; m_rr_lkp = 1'b1;
      chk("rst_busy", {63'd0, busy}, 0);
      chk("rst_done", {62'd0, ins_done, lkp_done}, 0);
      chk("rst_we", {63'd0, tbl_we}, 0);
      chk("rst_hit", {63'd0, lkp_hit}, 0);
      chk("rst_mlen", {58'd0, lkp_match_len}, 0);
      chk("rst_mpref", lkp_match_prefix, 0);
      chk("rst_hash_in", hash_in, 0);
    end else begin
      bit ed_i, ed_l;
      ed_i = (op == 1 && cyc == tdone);
      ed_l = (op == 2 && cyc == tdone);
      if (ed_l) begin e_hit = p_hit; e_mlen = p_len; e_mpref = p_pref; end
      if (op != 0 && cyc > t0) begin
        if (op == 1) e_hash = m_cur;
        else begin
          int k;
          k = (cyc - t0 - 1) / 2;
          if (k > m_kmax) k = m_kmax;
          e_hash = m_p & bmask(m_L - k);
        end
      end
      chk("busy", {63'd0, busy}, {63'd0, (op != 0 && cyc > t0)});
      chk("ins_done", {63'd0, ins_done}, {63'd0, ed_i});
      chk("tbl_we", {63'd0, tbl_we}, {63'd0, ed_i});
      chk("lkp_done", {63'd0, lkp_done}, {63'd0, ed_l});
      chk("lkp_hit", {63'd0, lkp_hit}, {63'd0, e_hit});
      chk("match_len", {58'd0, lkp_match_len}, {58'd0, e_mlen});
      chk("match_prefix", lkp_match_prefix, e_mpref);
      chk("hash_in", hash_in, e_hash);
      if (ed_i) begin
        chk("ins_tbl_len", {58'd0, tbl_len}, 64'(m_L));
        chk("ins_tbl_idx", {54'd0, tbl_idx}, {54'd0, h(m_cur)});
      end
      if (op == 2 && cyc >= t0 + 2 && cyc < tdone && ((cyc - t0 - 2) % 2) == 0) begin
        int k;
        k = (cyc - t0 - 2) / 2;
        chk("lkp_tbl_len", {58'd0, tbl_len}, 64'(m_L - k));
        chk("lkp_tbl_idx", {54'd0, tbl_idx}, {54'd0, h(m_p & bmask(m_L - k))});
      end
      if (op != 0 && cyc == tdone) op = 0;
      else if (op == 0 && (ins_req || lkp_req)) begin
        t0 = cyc;
        if (ins_req && (!lkp_req || m_rr_lkp)) begin
          op = 1; m_L = int'(ins_len); m_cur = ins_prefix & bmask(m_L);
          tdone = t0 + 2; m_rr_lkp = 1'b0;
          mset[m_L * 1024 + int'(h(m_cur))] = 1'b1;
        end else begin
          op = 2; m_p = lkp_prefix; m_L = int'(lkp_len); m_rr_lkp = 1'b1;
          p_hit = 0; p_len = '0; p_pref = '0; m_kmax = m_L;
          for (int l = m_L; l >= 0; l--) begin
            if (mset.exists(l * 1024 + int'(h(m_p & bmask(l))))) begin
              p_hit = 1; p_len = 6'(l); p_pref = m_p & bmask(l); m_kmax = m_L - l;
              break;
            end
          end
          tdone = t0 + 3 + 2 * m_kmax;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input bit is_ins, input logic [63:0] p, input logic [5:0] l,
                        output int t_req, output int t_done);
    int guard;
    @(posedge clk); #1;
    if (is_ins) begin ins_prefix = p; ins_len = l; ins_req = 1'b1; end
    else        begin lkp_prefix = p; lkp_len = l; lkp_req = 1'b1; end
    t_req = cyc; t_done = -1; guard = 0;
    while (t_done < 0 && guard < 300) begin
      @(negedge clk); guard++;
      if (is_ins ? ins_done : lkp_done) t_done = cyc;
    end
    @(posedge clk); #1;
    if (is_ins) ins_req = 1'b0; else lkp_req = 1'b0;
    if (t_done < 0) begin
      total++;
      $display("FAIL %s_timeout: no done within 300 cycles", is_ins ? "ins" : "lkp");
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  logic [63:0] pool [8];

  task automatic drv(input bit is_ins, input int n);
    bit seen;
    int g;
    for (int i = 0; i < n + 400; i++) begin
      @(negedge clk); seen = is_ins ? ins_done : lkp_done;
      @(posedge clk); #1;
      if (seen) begin
        if (is_ins) ins_req = 1'b0; else lkp_req = 1'b0;
      end else if (i < n && !(is_ins ? ins_req : lkp_req) && $urandom_range(0, 3) == 0) begin
        logic [63:0] p;
        logic [5:0] l;
        p = pool[$urandom_range(0, 7)] ^ ({$urandom, $urandom} << $urandom_range(8, 40));
        if (is_ins) begin
          l = 6'($urandom_range(0, 20));
          ins_prefix = p; ins_len = l; ins_req = 1'b1;
        end else begin
          l = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 24));
          lkp_prefix = p; lkp_len = l; lkp_req = 1'b1;
        end
      end
      if (i >= n && !(is_ins ? ins_req : lkp_req)) break;
    end
    g = is_ins ? int'(ins_req) : int'(lkp_req);
    if (g != 0) begin
      total++;
      $display("FAIL %s_drain: request still pending at end", is_ins ? "ins" : "lkp");
    end
  endtask

  int tr, td, ti, di, tl, dl, ld0;

  initial begin
    rst = 1'b1; ins_req = 0; lkp_req = 0;
    ins_prefix = '0; lkp_prefix = '0; ins_len = '0; lkp_len = '0;
    for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 0);
    chk("reset_hash_in", hash_in, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Lookup on an empty table: full miss from L=3.
    run_op(0, 64'h1234, 6'd3, tr, td);
    chk("empty_lat", 64'(td - tr), 9);
    chk("empty_hit", {63'd0, lkp_hit}, 0);
    chk("empty_mlen", {58'd0, lkp_match_len}, 0);
    chk("empty_mpref", lkp_match_prefix, 0);
    chk("empty_no_we", 64'(we_cnt), 0);

    // Insert 0xA5, L=7.
    run_op(1, 64'hA5, 6'd7, tr, td);
    chk("ins_lat", 64'(td - tr), 2);
    chk("ins_we_cyc", 64'(we_cyc - tr), 2);
    chk("ins_we_len", {58'd0, we_len}, 7);
    chk("ins_we_idx", {54'd0, we_idx}, {54'd0, h(64'hA5)});

    // LPM: 8 misses from 15 down to 8, hit at 7.
    run_op(0, 64'hFFA5, 6'd15, tr, td);
    chk("lpm_lat", 64'(td - tr), 19);
    chk("lpm_hit", {63'd0, lkp_hit}, 1);
    chk("lpm_mlen", {58'd0, lkp_match_len}, 7);
    chk("lpm_mpref", lkp_match_prefix, 64'hA5);

    // Length-0 entry and length-0 lookup.
    run_op(1, 64'h3, 6'd0, tr, td);
    run_op(0, 64'h77, 6'd0, tr, td);
    chk("len0_lat", 64'(td - tr), 3);
    chk("len0_hit", {63'd0, lkp_hit}, 1);
    chk("len0_mlen", {58'd0, lkp_match_len}, 0);
    chk("len0_mpref", lkp_match_prefix, 64'h1);

    // Ties after reset: insert first, then lookup; repeated tie alternates.
    pulse_reset();
    fork
      run_op(1, 64'h1F0, 6'd8, ti, di);
      run_op(0, 64'hA5, 6'd7, tl, dl);
    join
    chk("tie1_ins_lat", 64'(di - ti), 2);
    chk("tie1_lkp_lat", 64'(dl - tl), 6);
    fork
      run_op(1, 64'h1F0, 6'd8, ti, di);
      run_op(0, 64'hA5, 6'd7, tl, dl);
    join
    chk("tie2_ins_lat", 64'(di - ti), 2);
    chk("tie2_lkp_lat", 64'(dl - tl), 6);
    run_op(1, 64'h3C, 6'd5, tr, td);
    fork
      run_op(1, 64'h1F0, 6'd8, ti, di);
      run_op(0, 64'hA5, 6'd7, tl, dl);
    join
    chk("tie3_lkp_lat", 64'(dl - tl), 3);
    chk("tie3_ins_lat", 64'(di - ti), 6);

    // Reset while LK_CHECK sees a set bit: aborted, then normal operation.
    @(posedge clk); #1; lkp_prefix = 64'hA5; lkp_len = 6'd7; lkp_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_rd_bit", {63'd0, tbl_rd_bit}, 1);
    chk("abort_tbl_len", {58'd0, tbl_len}, 7);
    ld0 = ld_cnt;
    rst = 1'b1; lkp_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 0);
    chk("abort_hit", {63'd0, lkp_hit}, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_no_done", 64'(ld_cnt), 64'(ld0));
    run_op(0, 64'hA5, 6'd7, tr, td);
    chk("after_abort_lat", 64'(td - tr), 3);
    chk("after_abort_hit", {63'd0, lkp_hit}, 1);
    chk("after_abort_mlen", {58'd0, lkp_match_len}, 7);

    // Randomized concurrent traffic against the model.
    fork
      drv(1, 5000);
      drv(0, 5000);
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_idle", {63'd0, busy}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
